// File: rtl/pre_neuron_sram_pkg.sv
// Shared constants and types for the pre-neuron state SRAM controller.
package pre_neuron_sram_pkg;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_SRAM_DEPTH = 256;

  // Requester IDs double as bit positions in the packed req/gnt vectors.
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;
endpackage

// File: rtl/pre_neuron_sram_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; lock_i masks the host so the core keeps the bus.
module rr_arb2
  import pre_neuron_sram_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       lock_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic       rr_last_q, rr_last_d;
  logic [1:0] req_m;

  always_comb begin
    req_m = en_i ? req_i : 2'b00;
    if (lock_i) req_m[REQ_HOST] = 1'b0;
    gnt_o = req_m;
    // On a tie the requester that did not win last time goes first.
    if (&req_m) begin
      gnt_o = 2'b00;
      if (rr_last_q == REQ_HOST) gnt_o[REQ_CORE] = 1'b1;
      else                       gnt_o[REQ_HOST] = 1'b1;
    end
    rr_last_d = rr_last_q;
    if (gnt_o[REQ_CORE])      rr_last_d = REQ_CORE;
    else if (gnt_o[REQ_HOST]) rr_last_d = REQ_HOST;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_last_q <= REQ_HOST;
    else       rr_last_q <= rr_last_d;
  end
endmodule

// File: rtl/pre_neuron_sram_ctrl.sv
// Single-port pre-neuron SRAM access controller: core/host arbitration with
// core RMW lock, registered read-valid, and a full-array clear sweep.
module pre_neuron_sram_ctrl
  import pre_neuron_sram_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int                    SRAM_DEPTH  = DEF_SRAM_DEPTH,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
)(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  input  logic                  core_lock,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  SRAM_CS,
  output logic                  SRAM_WE,
  output logic [ADDR_WIDTH-1:0] SRAM_A,
  output logic [DATA_WIDTH-1:0] SRAM_D,
  input  logic [DATA_WIDTH-1:0] SRAM_Q
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SRAM_DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  clr_pend_q, clr_pend_d;
  logic                  clr_done_q, clr_done_d;
  logic                  lock_q, lock_d;
  logic [1:0]            rvld_q, rvld_d;
  logic [1:0]            req, gnt;
  logic                  clr_go, arb_en;

  // Starting a sweep steals the bus for that cycle, so the arbiter idles.
  assign clr_go = (state_q == ST_IDLE) && clr_pend_q && !lock_q;
  assign arb_en = (state_q == ST_IDLE) && !clr_go && !RST;

  assign req[REQ_CORE] = core_req;
  assign req[REQ_HOST] = host_req;

  rr_arb2 u_arb (
    .clk_i  (CLK),
    .rst_i  (RST),
    .en_i   (arb_en),
    .lock_i (lock_q),
    .req_i  (req),
    .gnt_o  (gnt)
  );

  assign core_gnt    = gnt[REQ_CORE];
  assign host_gnt    = gnt[REQ_HOST];
  assign core_rvalid = rvld_q[REQ_CORE];
  assign host_rvalid = rvld_q[REQ_HOST];
  assign core_rdata  = SRAM_Q;
  assign host_rdata  = SRAM_Q;
  assign clr_busy    = clr_pend_q;
  assign clr_done    = clr_done_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_pend_d = clr_pend_q | clr_start;
    clr_done_d = 1'b0;
    case (state_q)
      ST_IDLE:  if (clr_go) state_d = ST_CLEAR;
      ST_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          cnt_d      = '0;
          state_d    = ST_IDLE;
          clr_pend_d = 1'b0;
          clr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase

    lock_d = lock_q;
    if (gnt[REQ_CORE] && core_lock) lock_d = 1'b1;
    else if (!core_lock)            lock_d = 1'b0;

    rvld_d[REQ_CORE] = gnt[REQ_CORE] & ~core_we;
    rvld_d[REQ_HOST] = gnt[REQ_HOST] & ~host_we;
  end

  always_comb begin
    SRAM_CS = 1'b0;
    SRAM_WE = 1'b0;
    SRAM_A  = '0;
    SRAM_D  = '0;
    if (state_q == ST_CLEAR) begin
      SRAM_CS = 1'b1;
      SRAM_WE = 1'b1;
      SRAM_A  = cnt_q;
      SRAM_D  = CLEAR_VALUE;
    end else if (gnt[REQ_CORE]) begin
      SRAM_CS = 1'b1;
      SRAM_WE = core_we;
      SRAM_A  = core_addr;
      SRAM_D  = core_wdata;
    end else if (gnt[REQ_HOST]) begin
      SRAM_CS = 1'b1;
      SRAM_WE = host_we;
      SRAM_A  = host_addr;
      SRAM_D  = host_wdata;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      clr_pend_q <= 1'b0;
      clr_done_q <= 1'b0;
      lock_q     <= 1'b0;
      rvld_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_pend_q <= clr_pend_d;
      clr_done_q <= clr_done_d;
      lock_q     <= lock_d;
      rvld_q     <= rvld_d;
    end
  end
endmodule

// File: tb/tb_pre_neuron_sram_ctrl.sv
// Scoreboard bench: a behavioural model predicts each cycle's bus activity and
// read data; a negedge monitor pops and compares against the DUT.
module tb_pre_neuron_sram_ctrl;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int DEPTH = 256;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          core_req = 1'b0, core_we = 1'b0, core_lock = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          clr_start = 1'b0;
  logic          core_gnt, core_rvalid, host_gnt, host_rvalid;
  logic [DW-1:0] core_rdata, host_rdata;
  logic          clr_busy, clr_done, SRAM_CS, SRAM_WE;
  logic [AW-1:0] SRAM_A;
  logic [DW-1:0] SRAM_D;
  logic [DW-1:0] SRAM_Q;

  pre_neuron_sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRAM_DEPTH(DEPTH), .CLEAR_VALUE('0)) dut (
    .CLK(CLK), .RST(RST),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_lock(core_lock), .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .SRAM_CS(SRAM_CS), .SRAM_WE(SRAM_WE), .SRAM_A(SRAM_A), .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q)
  );

  always #5 CLK = ~CLK;

  // SRAM macro: 1-cycle synchronous read, read-before-write.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge CLK) if (SRAM_CS) begin
    SRAM_Q <= mem[SRAM_A];
    if (SRAM_WE) mem[SRAM_A] <= SRAM_D;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  int n_sweep = 0, n_done = 0;

  typedef struct packed {
    bit cg, hg, cs, we, busy, done;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;
  typedef struct { int cyc; logic [DW-1:0] data; } rd_t;

  exp_t exp_q[$];
  rd_t  core_q[$], host_q[$];

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  bit m_last_host = 1, m_lock = 0, m_pend = 0, m_sweep = 0, m_done = 0;
  int m_addr = 0;
  bit last_cg, last_hg;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Predict this cycle from the current inputs, update the model, advance one clock.
  task automatic tick();
    exp_t e;
    rd_t  r;
    bit   go, set_pend, cg, hg;
    e = '0;
    go = !m_sweep && m_pend && !m_lock;
    set_pend = clr_start && !m_pend;
    e.busy = m_pend;
    e.done = m_done;
    cg = 0; hg = 0;
    if (m_sweep) begin
      e.cs = 1; e.we = 1; e.a = AW'(m_addr); e.d = '0;
    end else if (!go) begin
      cg = core_req;
      hg = host_req && !m_lock;
      if (cg && hg) begin
        if (m_last_host) hg = 0; else cg = 0;
      end
      if (cg)      begin e.cs = 1; e.we = core_we; e.a = core_addr; e.d = core_wdata; end
      else if (hg) begin e.cs = 1; e.we = host_we; e.a = host_addr; e.d = host_wdata; end
    end
    e.cg = cg; e.hg = hg;
    exp_q.push_back(e);
    if (cg) begin
      if (core_we) ref_mem[core_addr] = core_wdata;
      else begin r.cyc = cyc + 1; r.data = ref_mem[core_addr]; core_q.push_back(r); end
    end
    if (hg) begin
      if (host_we) ref_mem[host_addr] = host_wdata;
      else begin r.cyc = cyc + 1; r.data = ref_mem[host_addr]; host_q.push_back(r); end
    end
    if (m_sweep) ref_mem[m_addr] = '0;
    m_done = 0;
    if (cg) m_last_host = 0; else if (hg) m_last_host = 1;
    if (cg && core_lock) m_lock = 1; else if (!core_lock) m_lock = 0;
    if (m_sweep) begin
      if (m_addr == DEPTH - 1) begin m_sweep = 0; m_pend = 0; m_done = 1; m_addr = 0; end
      else m_addr++;
    end else if (go) m_sweep = 1;
    if (set_pend) m_pend = 1;
    last_cg = cg; last_hg = hg;
    @(posedge CLK); #1;
  endtask

  task automatic apply_reset(input bit check_now);
    RST = 1'b1;
    #1;
    if (check_now) begin
      chk("rst_core_gnt", 64'(core_gnt), 0);
      chk("rst_host_gnt", 64'(host_gnt), 0);
      chk("rst_core_rvalid", 64'(core_rvalid), 0);
      chk("rst_host_rvalid", 64'(host_rvalid), 0);
      chk("rst_clr_busy", 64'(clr_busy), 0);
      chk("rst_clr_done", 64'(clr_done), 0);
      chk("rst_sram_cs", 64'(SRAM_CS), 0);
    end
    exp_q.delete(); core_q.delete(); host_q.delete();
    m_last_host = 1; m_lock = 0; m_pend = 0; m_sweep = 0; m_done = 0; m_addr = 0;
    core_req = 0; host_req = 0; core_lock = 0; clr_start = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic run_until_clear_done();
    for (int k = 0; k < 600 && m_pend; k++) tick();
    repeat (2) tick();
  endtask

  // Monitor
  initial begin
    exp_t e;
    rd_t  r;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("core_gnt", 64'(core_gnt), 64'(e.cg));
        chk("host_gnt", 64'(host_gnt), 64'(e.hg));
        chk("sram_cs", 64'(SRAM_CS), 64'(e.cs));
        chk("sram_we", 64'(SRAM_WE), 64'(e.we));
        chk("sram_a", 64'(SRAM_A), 64'(e.a));
        chk("sram_d", 64'(SRAM_D), 64'(e.d));
        chk("clr_busy", 64'(clr_busy), 64'(e.busy));
        chk("clr_done", 64'(clr_done), 64'(e.done));
      end
      if (SRAM_CS && SRAM_WE && !core_gnt && !host_gnt) n_sweep++;
      if (clr_done) n_done++;
      if (core_rvalid || (core_q.size() > 0 && core_q[0].cyc <= cyc)) begin
        if (core_q.size() == 0) chk("core_rvalid_spurious", 64'(core_rvalid), 0);
        else begin
          r = core_q.pop_front();
          chk("core_rvalid", 64'(core_rvalid), 1);
          chk("core_rvalid_cycle", 64'(cyc), 64'(r.cyc));
          if (core_rvalid) chk("core_rdata", 64'(core_rdata), 64'(r.data));
        end
      end
      if (host_rvalid || (host_q.size() > 0 && host_q[0].cyc <= cyc)) begin
        if (host_q.size() == 0) chk("host_rvalid_spurious", 64'(host_rvalid), 0);
        else begin
          r = host_q.pop_front();
          chk("host_rvalid", 64'(host_rvalid), 1);
          chk("host_rvalid_cycle", 64'(cyc), 64'(r.cyc));
          if (host_rvalid) chk("host_rdata", 64'(host_rdata), 64'(r.data));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0, w0;
    // Requests held through reset must not be granted.
    core_req = 1; host_req = 1;
    @(posedge CLK); #1;
    apply_reset(1);

    // Core write then read of 0x05
    core_req = 1; core_we = 1; core_addr = 8'h05; core_wdata = 32'hDEADBEEF;
    tick();
    core_we = 0;
    tick();
    core_req = 0;
    repeat (2) tick();

    // Full clear sweep, then read the top word
    d0 = n_done; w0 = n_sweep;
    clr_start = 1; tick(); clr_start = 0;
    run_until_clear_done();
    chk("sweep_writes", 64'(n_sweep - w0), 64'(DEPTH));
    chk("clr_done_pulses", 64'(n_done - d0), 1);
    core_req = 1; core_we = 0; core_addr = 8'hFF;
    tick();
    core_req = 0;
    repeat (2) tick();

    // Both requesters held from reset: grants alternate
    apply_reset(0);
    core_req = 1; host_req = 1; core_we = 0; host_we = 0; core_addr = 8'h05; host_addr = 8'h08;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (last_cg) core_addr = core_addr + 1'b1;
      if (last_hg) host_addr = host_addr + 1'b1;
    end
    core_req = 0; host_req = 0;
    repeat (2) tick();

    // Locked read-modify-write with host waiting
    host_req = 1; host_we = 0; host_addr = 8'h10;
    core_req = 1; core_we = 0; core_addr = 8'h10; core_lock = 1;
    tick();
    core_we = 1; core_wdata = 32'h1234_5678; core_lock = 0;
    tick();
    core_req = 0;
    for (int k = 0; k < 4 && host_req; k++) begin
      tick();
      if (last_hg) host_req = 0;
    end
    repeat (2) tick();

    // Clear deferred by lock, then a second start mid-sweep is ignored
    core_req = 1; core_we = 0; core_addr = 8'h20; core_lock = 1;
    tick();
    core_req = 0;
    clr_start = 1; tick(); clr_start = 0;
    repeat (5) tick();
    d0 = n_done;
    core_lock = 0;
    repeat (80) tick();
    clr_start = 1; tick(); clr_start = 0;
    run_until_clear_done();
    chk("clr_done_once", 64'(n_done - d0), 1);

    // Reset in the middle of a sweep, then restart from address 0
    clr_start = 1; tick(); clr_start = 0;
    for (int k = 0; k < 300 && !(m_sweep && m_addr == 100); k++) tick();
    chk("pre_rst_sweep_addr", 64'(SRAM_A), 100);
    apply_reset(1);
    w0 = n_sweep;
    clr_start = 1; tick(); clr_start = 0;
    run_until_clear_done();
    chk("restart_sweep_writes", 64'(n_sweep - w0), 64'(DEPTH));

    // Randomized traffic with occasional locks and clears
    for (int i = 0; i < 2000; i++) begin
      if (!core_req || last_cg) begin
        core_req = ($urandom_range(0, 2) != 0);
        core_we = 1'($urandom_range(0, 1));
        core_addr = AW'($urandom_range(0, 255));
        core_wdata = $urandom;
      end
      if (!host_req || last_hg) begin
        host_req = ($urandom_range(0, 2) != 0);
        host_we = 1'($urandom_range(0, 1));
        host_addr = AW'($urandom_range(0, 255));
        host_wdata = $urandom;
      end
      core_lock = ($urandom_range(0, 3) == 0);
      clr_start = ($urandom_range(0, 399) == 0);
      tick();
    end
    core_req = 0; host_req = 0; core_lock = 0; clr_start = 0;
    run_until_clear_done();
    chk("core_reads_drained", 64'(core_q.size()), 0);
    chk("host_reads_drained", 64'(host_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pre_neuron_sram_ctrl.md
Name: pre_neuron_sram_ctrl

Overview:
Access controller for the single-port pre-neuron state SRAM (1-cycle synchronous read, read-before-write, CS/WE/A/D/Q interface). It shares the macro between the core neuron-update engine and the host/configuration port through a 2-way round-robin arbiter with a core lock for atomic read-modify-write. It also owns a clear-sweep engine that writes CLEAR_VALUE to every word at timestep/sample boundaries. The block sits between the FF-STDP core controller, the SPI/host slave and the SRAM instance.

Parameters:
ADDR_WIDTH, 8, SRAM address width
DATA_WIDTH, 32, SRAM word width
SRAM_DEPTH, 256, number of words swept by clear (must be ≤ 2^ADDR_WIDTH)
CLEAR_VALUE, 0, word written during clear sweep

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
core_req  in  1  core access request, held until granted
core_we  in  1  1=write, 0=read
core_addr  in  ADDR_WIDTH  core address
core_wdata  in  DATA_WIDTH  core write data
core_lock  in  1  keep bus ownership after the current grant (RMW)
core_gnt  out  1  access issued to SRAM this cycle
core_rvalid  out  1  core read data valid
core_rdata  out  DATA_WIDTH  core read data
host_req / host_we / host_addr / host_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  same as core
host_gnt / host_rvalid / host_rdata  out  1/1/DATA_WIDTH  same as core
clr_start  in  1  pulse: request a clear sweep
clr_busy  out  1  sweep pending or in progress
clr_done  out  1  one-cycle pulse after last word written
SRAM_CS / SRAM_WE  out  1/1  to macro
SRAM_A  out  ADDR_WIDTH  to macro
SRAM_D  out  DATA_WIDTH  to macro
SRAM_Q  in  DATA_WIDTH  from macro

Behaviour:
- Reset (async, RST=1): FSM=IDLE, gnts=0, rvalid=0, clr_busy=0, clr_done=0, clr_pending=0, sweep counter=0, rr_last=HOST (core wins first tie), lock_owner=0.
- Grants are combinational from registered state and current requests; SRAM_CS = OR of gnts or sweep write; SRAM_A/D/WE muxed from the winner. Non-granted cycles: SRAM_CS=0, A/D/WE=0.
- One access per cycle. Request is consumed on the cycle its gnt=1; requester may change inputs next cycle.
- Arbitration in IDLE: single requester wins; both requesting -> winner is the one not equal to rr_last; rr_last updates on every grant.
- Lock: if core_gnt=1 and core_lock=1, lock_owner set; while lock_owner=1, host_gnt=0 and clear cannot start; lock_owner clears the first cycle core_lock=0.
- Read latency: rvalid asserted exactly 1 cycle after a granted read (registered); rdata = SRAM_Q (combinational pass-through to both ports, valid only with rvalid). Granted write -> no rvalid.
- Clear: clr_start sets clr_pending (clr_busy=1 immediately next cycle). FSM IDLE->CLEAR when clr_pending=1 and lock_owner=0; clear has priority over new requests that cycle. CLEAR: SRAM_CS=1, WE=1, A=counter, D=CLEAR_VALUE, counter++ each cycle, both gnts=0. After A=SRAM_DEPTH-1: counter->0, FSM->IDLE, clr_pending=0, clr_done=1 for one cycle, clr_busy=0 same cycle as clr_done.
- clr_start while busy: ignored (no second sweep).
- Counter width ADDR_WIDTH; terminal compare against SRAM_DEPTH-1, no wrap beyond.
- Reset mid-sweep: sweep aborted, SRAM contents partially cleared (unspecified), all outputs to reset values.

Decomposition:
- Package pre_neuron_sram_pkg: FSM state encoding (IDLE, CLEAR), requester ID constants (REQ_CORE=0, REQ_HOST=1), default widths/depth.
- Sub-module rr_arb2: 2-requester round-robin with rr_last register and lock input; FSM, sweep counter and rvalid pipeline stay in top.

Test Plan:
- Core write addr 0x05 data 0xDEADBEEF, then core read 0x05 -> core_gnt both cycles; core_rvalid 1 cycle after read gnt, core_rdata=0xDEADBEEF; host_rvalid=0.
- core_req and host_req both held 4 cycles, reads, from reset -> grants alternate core,host,core,host; each rvalid goes only to its owner.
- Core read 0x10 with core_lock=1, host_req held, core write 0x10 next cycle with core_lock=0 -> host_gnt=0 for both core cycles, host granted on the following cycle.
- clr_start with SRAM_DEPTH=256 -> 256 consecutive writes of 0 at A=0..255, gnts=0 throughout, clr_done pulses once; subsequent read of 0xFF returns 0.
- clr_start while core_lock owned -> sweep deferred until lock releases, clr_busy=1 during wait; second clr_start mid-sweep -> exactly one clr_done.
- RST asserted at sweep address 100 -> clr_busy, clr_done, gnts, rvalid all 0 same cycle; new clr_start restarts at A=0.
